// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module      : serial_add_ctrl (with helper cell fulladder)
// Description : Bit-serial adder controller. One full-adder cell is
//               time-shared across a WIDTH-bit operand pair, one bit per
//               clock, LSB first. Operands are captured on an accepted start,
//               the ripple carry is held in a register between bits, and the
//               finished sum/carry-out are presented with a one-cycle done
//               pulse. Results are held until the next accepted start.
//
// Parameters  : WIDTH  operand/sum width in bits, legal range 1..32
//
// Ports       : clk    in   1      rising-edge clock
//               rst_n  in   1      asynchronous active-low reset
//               start  in   1      begin an addition (ignored while busy)
//               a      in   WIDTH  operand A, captured on the accepting edge
//               b      in   WIDTH  operand B, captured on the accepting edge
//               cin    in   1      carry-in, captured on the accepting edge
//               busy   out  1      high while bits are being processed
//               done   out  1      one-cycle pulse, sum/cout valid
//               sum    out  WIDTH  result, held until next accepted start
//               cout   out  1      carry out of the MSB, held with sum
//               ovf    out  1      signed overflow (SERIAL_ADD_OVF_EN only)
//
// Options     : SERIAL_ADD_OVF_EN  when defined, adds the ovf output and its
//                                  register; when undefined both are absent.
//
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------

`default_nettype none

//------------------------------------------------------------------------------
// fulladder : single-bit combinational full adder
//   a_i, b_i, c_i : addend bits and carry-in
//   s_o, c_o      : sum bit and carry-out
//------------------------------------------------------------------------------
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

//------------------------------------------------------------------------------
// serial_add_ctrl : sequencer around one fulladder instance
//------------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The bit counter only has to reach WIDTH-1; keep at least one bit so the
  // WIDTH=1 build still has a legal vector.
  localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic               carry_q,  carry_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   sum_q,    sum_d;
  logic               cout_q,   cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q,    ovf_d;
`endif

  logic               fa_s;
  logic               fa_c;
  logic [WIDTH-1:0]   sum_shift;
  logic               accept;

  //----------------------------------------------------------------------------
  // The one and only datapath cell: LSBs of the shifting operands plus the
  // carry held from the previous bit.
  //----------------------------------------------------------------------------
  fulladder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  //----------------------------------------------------------------------------
  // New sum bits enter at the MSB and move right, so after WIDTH shifts the
  // first (LSB) result bit has arrived at position 0.
  //----------------------------------------------------------------------------
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // Start is honoured in IDLE and in DONE (back-to-back), never in RUN.
  assign accept = start && (state_q != RUN);

  //----------------------------------------------------------------------------
  // Next-state and datapath update
  //----------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end

      RUN: begin
        sum_d   = sum_shift;
        carry_d = fa_c;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + C_CNT_ONE;
        if (cnt_q == C_CNT_LAST) begin
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB is still in carry_q on the final bit.
          ovf_d   = carry_q ^ fa_c;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept overrides the IDLE/DONE defaults above.
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = 1'b0;
`endif
      state_d = RUN;
    end
  end

  //----------------------------------------------------------------------------
  // State and datapath registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status outputs are pure decodes of the state register (Moore).
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl. Stimulus pushes the
//               expected result (from plain integer arithmetic) into a queue;
//               a monitor pops and compares whenever done is presented.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------

`default_nettype none

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               at;
  } exp_t;

  exp_t             q[$];
  int               checks    = 0;
  int               errors    = 0;
  int               last_acc  = -1000;
  bit               have_last = 1'b0;
  logic [WIDTH-1:0] last_sum  = '0;
  logic             last_cout = 1'b0;

  // Reference: unsigned and signed integer sums of the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input int at);
    exp_t   r;
    longint u, sx, sy, ss, maxv, minv;
    u    = longint'(x) + longint'(y) + longint'(ci);
    r.sum  = u[WIDTH-1:0];
    r.cout = u[WIDTH];
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ss   = sx + sy + longint'(ci);
    maxv = (longint'(1) << (WIDTH - 1)) - 1;
    minv = -(longint'(1) << (WIDTH - 1));
    r.ovf = (ss > maxv) || (ss < minv);
    r.at  = at;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every falling edge, outside reset.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      chk("busy", 64'(busy), 64'((cyc >= last_acc) && (cyc < last_acc + WIDTH)));
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.at));
          chk("sum", 64'(sum), 64'(e.sum));
          chk("cout", 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
          chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
          last_sum  = e.sum;
          last_cout = e.cout;
          have_last = 1'b1;
        end
      end else begin
        if (q.size() > 0 && q[0].at <= cyc) begin
          chk("missing_done", 64'(done), 64'd1);
          void'(q.pop_front());
        end
        if (!busy && have_last) begin
          chk("sum_hold", 64'(sum), 64'(last_sum));
          chk("cout_hold", 64'(cout), 64'(last_cout));
        end
      end
    end
  end

  task automatic do_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_idle", 64'(busy), 64'd0);
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    acc       = cyc;
    last_acc  = cyc;
    have_last = 1'b0;
    q.push_back(model(x, y, ci, cyc + WIDTH));
  endtask

  initial begin
    int acc1, acc2, tmp, guard;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  64'(sum),  64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf",  64'(ovf),  64'd0);
`endif
    have_last = 1'b1;
    rst_n     = 1'b1;

    // Directed cases
    do_add(8'h5A, 8'h3C, 1'b0, tmp);
    do_add(8'hFF, 8'h01, 1'b0, tmp);
    do_add(8'hFF, 8'hFF, 1'b1, tmp);

    // Start during RUN must be ignored
    do_add(8'h01, 8'h01, 1'b0, tmp);
    repeat (3) @(negedge clk);
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Back-to-back: second accept lands on the DONE cycle of the first
    do_add(8'h03, 8'h04, 1'b0, acc1);
    do_add(8'h0F, 8'h01, 1'b0, acc2);
    chk("b2b_gap", 64'(acc2 - acc1), 64'(WIDTH + 1));

    // Asynchronous reset in the middle of RUN
    do_add(8'hA5, 8'h5A, 1'b1, tmp);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum",  64'(sum),  64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    q.delete();
    last_acc  = -1000;
    last_sum  = '0;
    last_cout = 1'b0;
    have_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    do_add(8'h22, 8'h33, 1'b0, tmp);

    // Signed-overflow corners (ovf is checked only when present)
    do_add(8'h7F, 8'h01, 1'b0, tmp);
    do_add(8'h80, 8'h80, 1'b0, tmp);
    do_add(8'h10, 8'h20, 1'b0, tmp);

    // Randomised operands with random idle gaps
    for (int i = 0; i < 40; i++) begin
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), tmp);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    // Drain outstanding results
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
